// File: rtl/cps_serial_seq_pkg.sv
// Shared types and sizing helpers for the slice-serial subtract sequencer.
package cps_serial_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  // Counter width never drops below one bit, even for a single-slice build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N     = WIDTH_DEF / SLICE_DEF;
  localparam int CNT_W = cnt_width(N);

endpackage

// File: rtl/cps_serial_seq_if.sv
// Start/done operand and result bundle between the operand source and the sequencer.
interface cps_serial_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, s, c_out
  );

endinterface

// File: rtl/cps_slice.sv
// Combinational SLICE-bit ripple full-subtract chain: {bout, d} = a - b - bin.
module cps_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] w_br;

  always_comb begin
    w_br    = '0;
    d       = '0;
    w_br[0] = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i]      = a[i] ^ b[i] ^ w_br[i];
      w_br[i+1] = (~(a[i] ^ b[i]) & w_br[i]) | (~a[i] & b[i]);
    end
    bout = w_br[SLICE];
  end

endmodule

// File: rtl/cps_serial_seq.sv
// Slice-serial subtractor: one SLICE-bit subtract per clock, LSB slice first,
// with a registered borrow chaining the slices. Result registers update only on completion.
module cps_serial_seq
  import cps_serial_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  cps_serial_seq_if.slave bus
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = cnt_width(NS);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("cps_serial_seq: WIDTH must be an integer multiple of SLICE");
    end
  endgenerate

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic [SLICE-1:0] w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  cps_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // New slice enters at the MSB end so the LSB slice lands at the bottom after N shifts.
  assign w_res_nxt = (r_res >> SLICE) | (WIDTH'(w_d) << (WIDTH - SLICE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(NS - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.c_in;
        r_res    <= '0;
        r_cnt    <= '0;
      end else if (r_state == ST_RUN) begin
        r_a      <= r_a >> SLICE;
        r_b      <= r_b >> SLICE;
        r_res    <= w_res_nxt;
        r_borrow <= w_bout;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_s    <= w_res_nxt;
          r_cout <= w_bout;
        end
      end
    end
  end

  assign bus.busy  = (r_state == ST_RUN);
  assign bus.done  = r_done;
  assign bus.s     = r_s;
  assign bus.c_out = r_cout;

endmodule

// File: tb/tb_cps_serial_seq.sv
// Scoreboard bench for cps_serial_seq: expected results queued at start, checked on done.
module tb_cps_serial_seq;
  import cps_serial_seq_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cps_serial_seq_if #(.WIDTH(W)) sif ();

  cps_serial_seq #(.WIDTH(W), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
    return '{s: r[W-1:0], c: r[W]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (sif.done) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'(sif.done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("s", 32'(sif.s), 32'(e.s));
        check("c_out", 32'(sif.c_out), 32'(e.c));
      end
    end
  end

  // Called one step after an edge with the DUT idle; returns one step after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    sif.a     = a;
    sif.b     = b;
    sif.c_in  = ci;
    sif.start = 1'b1;
    q.push_back(model(a, b, ci));
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.a     = W'($urandom);
    sif.b     = W'($urandom);
    sif.c_in  = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input bit hold_en, input logic [W-1:0] hold_s,
                           input bit lat_en);
    int n  = 0;
    int nb = 0;
    if (sif.busy) nb++;
    while (!sif.done && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (sif.busy) nb++;
      if (hold_en && !sif.done) check({tag, "_hold"}, 32'(sif.s), 32'(hold_s));
    end
    if (!sif.done) check({tag, "_timeout"}, 32'(sif.done), 32'd1);
    if (lat_en) begin
      check({tag, "_latency"}, 32'(n), 32'(N));
      check({tag, "_busy_cycles"}, 32'(nb), 32'(N));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.c_in  = 1'b0;

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_s", 32'(sif.s), 32'h0);
    check("rst_c_out", 32'(sif.c_out), 32'd0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    issue(16'h1234, 16'h0234, 1'b0);
    wait_done("basic", 1'b0, '0, 1'b1);
    check("basic_s", 32'(sif.s), 32'h1000);
    @(posedge clk); #1;
    check("done_pulse", 32'(sif.done), 32'd0);

    issue(16'h0000, 16'h0001, 1'b0);
    wait_done("wrap0", 1'b0, '0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("wrapF", 1'b0, '0, 1'b1);
    issue(16'h8000, 16'h0000, 1'b1);
    wait_done("msb", 1'b0, '0, 1'b1);
    @(posedge clk); #1;

    // Start while busy must be dropped.
    issue(16'h1234, 16'h0234, 1'b0);
    sif.a     = 16'h0001;
    sif.b     = 16'h0001;
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    wait_done("ignore", 1'b0, '0, 1'b0);
    check("ignore_s", 32'(sif.s), 32'h1000);
    repeat (6) begin
      @(posedge clk); #1;
      check("ignore_no_done", 32'(sif.done), 32'd0);
    end

    // Back-to-back: new start in the done cycle.
    issue(16'h1234, 16'h0234, 1'b0);
    wait_done("b2b_first", 1'b0, '0, 1'b1);
    issue(16'h0010, 16'h0020, 1'b0);
    wait_done("b2b_second", 1'b1, 16'h1000, 1'b1);
    check("b2b_s", 32'(sif.s), 32'hFFF0);
    @(posedge clk); #1;

    // Reset in the middle of a run abandons it.
    issue(16'h1234, 16'h0234, 1'b0);
    @(posedge clk); #1;
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    check("mid_rst_s", 32'(sif.s), 32'h0);
    #2 rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", 32'(sif.done), 32'd0);
    end
    issue(16'h0005, 16'h0003, 1'b0);
    wait_done("post_rst", 1'b0, '0, 1'b1);
    check("post_rst_s", 32'(sif.s), 32'h0002);

    // Random operands with random gaps, back-to-back starts and ignored mid-run starts.
    for (int i = 0; i < 10000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
      end
      wait_done("rnd", 1'b0, '0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
